// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//  Definitions shared by the UART transmitter and the future receiver.
//  Contents:
//   TMR_W                 width of the external bit-timer reload value
//   DEFAULT_CLKS_PER_BIT  clocks per serial bit at 50 MHz / 115200 baud
//   uart_state_t          frame state machine encoding
//   tmr_load()            reload value handed to the bit timer for a period
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int TMR_W                = 13;
   localparam int DEFAULT_CLKS_PER_BIT = 434;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   // The timer counts its reload value down to zero, so a period of N
   // clocks is programmed as N-1.
   function automatic logic [TMR_W-1:0] tmr_load(input int clks);
      return TMR_W'(clks - 1);
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// ---------------------------------------------------------------------------
// uart_tx_if
//  Byte handshake between a producer and the UART transmitter.
//  Signals:
//   tx_data   byte to send, sampled only when tx_valid & tx_ready
//   tx_valid  producer has a byte and holds it until accepted
//   tx_ready  transmitter idle and able to accept
//   tx_busy   frame in progress (inverse of tx_ready)
//  Modports:
//   master    producer side
//   slave     transmitter side
// ---------------------------------------------------------------------------
interface uart_tx_if #(
   parameter int DATA_BITS = 8
);

   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic                 tx_busy;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  tx_busy
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output tx_busy
   );

endinterface

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//  UART transmit serializer. Accepts a byte on the bus handshake and shifts
//  out start bit, data bits (LSB first), optional even parity and stop bits
//  on txd. Bit periods are timed by an external down-counting timer: every
//  bit starts with a one-cycle tmr_set pulse and ends on the next tmr_done.
//
//  Build option: define UART_TX_PARITY_EN to insert an even parity bit after
//  the data bits. Without it there is no parity state, flop or logic and the
//  last data bit is followed directly by the stop bit(s).
//
//  Parameters:
//   CLKS_PER_BIT  clocks per serial bit (3..8192)
//   DATA_BITS     data bits per frame (5..8)
//   STOP_BITS     stop bits per frame (1 or 2)
//  Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   bus        byte handshake (slave side of uart_tx_if)
//   txd        registered serial output, idles high
//   tmr_set    registered one-cycle pulse starting each bit period
//   tmr_value  timer reload, constant CLKS_PER_BIT-1
//   tmr_done   timer expiry pulse, ignored while idle
// ---------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_if.slave         bus,
   output logic             txd,
   output logic             tmr_set,
   output logic [TMR_W-1:0] tmr_value,
   input  logic             tmr_done
);

   localparam int CNT_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
   localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

   uart_state_t          state_reg,    state_next;
   logic [DATA_BITS-1:0] shift_reg,    shift_next;
   logic [CNT_W-1:0]     bit_cnt_reg,  bit_cnt_next;
   logic                 stop_idx_reg, stop_idx_next;
   logic                 txd_reg,      txd_next;
   logic                 tmr_set_reg,  tmr_set_next;
`ifdef UART_TX_PARITY_EN
   logic                 parity_reg,   parity_next;
`endif

   // -----------------------------------------------------------------------
   // State register
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         shift_reg    <= '0;
         bit_cnt_reg  <= '0;
         stop_idx_reg <= 1'b0;
         txd_reg      <= 1'b1;
         tmr_set_reg  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_reg   <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         shift_reg    <= shift_next;
         bit_cnt_reg  <= bit_cnt_next;
         stop_idx_reg <= stop_idx_next;
         txd_reg      <= txd_next;
         tmr_set_reg  <= tmr_set_next;
`ifdef UART_TX_PARITY_EN
         parity_reg   <= parity_next;
`endif
      end
   end

   // -----------------------------------------------------------------------
   // Next-state and output logic. txd and tmr_set are computed one cycle
   // ahead so both leave the block straight from flops; tmr_set is only
   // raised on transitions into a non-idle state, so it can never coincide
   // with tx_ready.
   // -----------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      shift_next    = shift_reg;
      bit_cnt_next  = bit_cnt_reg;
      stop_idx_next = stop_idx_reg;
      txd_next      = txd_reg;
      tmr_set_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_next   = parity_reg;
`endif

      case (state_reg)
         IDLE: begin
            txd_next = 1'b1;
            if (bus.tx_valid) begin
               shift_next    = bus.tx_data;
               bit_cnt_next  = '0;
               stop_idx_next = 1'b0;
               txd_next      = 1'b0;
               tmr_set_next  = 1'b1;
               state_next    = START;
`ifdef UART_TX_PARITY_EN
               // Even parity is captured with the byte so the data shift
               // register can be consumed freely during the frame.
               parity_next   = ^bus.tx_data;
`endif
            end
         end

         START: begin
            if (tmr_done) begin
               txd_next     = shift_reg[0];
               shift_next   = {1'b0, shift_reg[DATA_BITS-1:1]};
               bit_cnt_next = '0;
               tmr_set_next = 1'b1;
               state_next   = DATA;
            end
         end

         DATA: begin
            if (tmr_done) begin
               tmr_set_next = 1'b1;
               if (bit_cnt_reg == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                  txd_next   = parity_reg;
                  state_next = PARITY;
`else
                  txd_next   = 1'b1;
                  state_next = STOP;
`endif
               end else begin
                  txd_next     = shift_reg[0];
                  shift_next   = {1'b0, shift_reg[DATA_BITS-1:1]};
                  bit_cnt_next = bit_cnt_reg + 1'b1;
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (tmr_done) begin
               txd_next     = 1'b1;
               tmr_set_next = 1'b1;
               state_next   = STOP;
            end
         end
`endif

         STOP: begin
            txd_next = 1'b1;
            if (tmr_done) begin
               if (stop_idx_reg != LAST_STOP) begin
                  stop_idx_next = stop_idx_reg + 1'b1;
                  tmr_set_next  = 1'b1;
               end else begin
                  // Last stop bit ends without a new timer period; the
                  // line simply stays high in IDLE.
                  state_next = IDLE;
               end
            end
         end

         default: begin
            txd_next   = 1'b1;
            state_next = IDLE;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // Outputs
   // -----------------------------------------------------------------------
   assign bus.tx_ready = (state_reg == IDLE);
   assign bus.tx_busy  = (state_reg != IDLE);
   assign txd          = txd_reg;
   assign tmr_set      = tmr_set_reg;
   assign tmr_value    = tmr_load(CLKS_PER_BIT);

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
//  Directed bench for uart_tx with CLKS_PER_BIT=4. Instance 0 uses one stop
//  bit, instance 1 two stop bits. A behavioural bit timer per instance
//  follows the timer contract (reload on tmr_set, done pulse so the DUT
//  samples it CLKS_PER_BIT edges after the accepting edge).
//  Expected frames are hand-computed constants, LSB = first bit on the line.
//  Honours UART_TX_PARITY_EN when compiled with it.
// ---------------------------------------------------------------------------
module tb_uart_tx;
   import uart_pkg::*;

   localparam int C = 4;

`ifdef UART_TX_PARITY_EN
   localparam int          NB      = 11;
   localparam logic [11:0] EXP_A5  = 12'h54A;
   localparam logic [11:0] EXP_07  = 12'h60E;
   localparam logic [11:0] EXP_00  = 12'h400;
   localparam logic [11:0] EXP_FF  = 12'h5FE;
   localparam logic [11:0] EXP_3C2 = 12'hC78;
`else
   localparam int          NB      = 10;
   localparam logic [11:0] EXP_A5  = 12'h34A;
   localparam logic [11:0] EXP_07  = 12'h20E;
   localparam logic [11:0] EXP_00  = 12'h200;
   localparam logic [11:0] EXP_FF  = 12'h3FE;
   localparam logic [11:0] EXP_3C2 = 12'h678;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_if #(.DATA_BITS(8)) bus0 ();
   uart_tx_if #(.DATA_BITS(8)) bus1 ();

   logic [7:0]       data_v  [2];
   logic             valid_v [2];
   logic             txd0, txd1, set0, set1, done0, done1;
   logic [TMR_W-1:0] val0, val1;
   logic             force_done;

   assign bus0.tx_data  = data_v[0];
   assign bus0.tx_valid = valid_v[0];
   assign bus1.tx_data  = data_v[1];
   assign bus1.tx_valid = valid_v[1];

   uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1)) u_dut0 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus0),
      .txd       (txd0),
      .tmr_set   (set0),
      .tmr_value (val0),
      .tmr_done  (done0)
   );

   uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(2)) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus1),
      .txd       (txd1),
      .tmr_set   (set1),
      .tmr_value (val1),
      .tmr_done  (done1)
   );

   function automatic logic get_txd(input int idx);
      return (idx == 1) ? txd1 : txd0;
   endfunction

   function automatic logic get_set(input int idx);
      return (idx == 1) ? set1 : set0;
   endfunction

   function automatic logic get_ready(input int idx);
      return (idx == 1) ? bus1.tx_ready : bus0.tx_ready;
   endfunction

   function automatic logic [TMR_W-1:0] get_val(input int idx);
      return (idx == 1) ? val1 : val0;
   endfunction

   // Bit timer model: reload on tmr_set, pulse done when the count passes 2
   // so the DUT samples it exactly C edges after the period started.
   logic [TMR_W-1:0] tcnt  [2];
   logic             tdone [2];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         tdone[i] <= 1'b0;
         if (rst) begin
            tcnt[i] <= '0;
         end else if (get_set(i)) begin
            tcnt[i] <= get_val(i);
         end else if (tcnt[i] != '0) begin
            tcnt[i] <= tcnt[i] - 1'b1;
            if (tcnt[i] == TMR_W'(2))
               tdone[i] <= 1'b1;
         end
      end
   end

   assign done0 = tdone[0] | force_done;
   assign done1 = tdone[1];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // tmr_set and tx_ready must never be high together.
   always @(negedge clk) begin
      if (!rst && set0 && bus0.tx_ready) check("set_ready_overlap0", 32'(1), 32'(0));
      if (!rst && set1 && bus1.tx_ready) check("set_ready_overlap1", 32'(1), 32'(0));
   end

   // Send one byte and check every bit period sample by sample.
   task automatic run_frame(input int idx, input logic [7:0] d, input int nbits,
                            input logic [11:0] expb, input bit hold,
                            input logic [7:0] next_d, input bit disturb,
                            output time t_acc);
      int         wait_n = 0;
      int         sets   = 0;
      logic [C-1:0] samp;
      @(negedge clk);
      data_v[idx]  = d;
      valid_v[idx] = 1'b1;
      while (!get_ready(idx) && wait_n < 200) begin
         @(negedge clk);
         wait_n++;
      end
      check($sformatf("accept_wait dut%0d", idx), 32'(wait_n < 200), 32'(1));
      @(posedge clk);
      t_acc = $time;
      #1;
      if (hold) data_v[idx] = next_d;
      else      valid_v[idx] = 1'b0;
      for (int b = 0; b < nbits; b++) begin
         samp = '0;
         for (int j = 0; j < C; j++) begin
            samp[j] = get_txd(idx);
            if (get_set(idx)) sets++;
            if (disturb && b == 3 && j == 1) begin
               data_v[idx]  = ~d;
               valid_v[idx] = 1'b1;
            end
            if (disturb && b == 3 && j == 3) begin
               data_v[idx]  = d;
               valid_v[idx] = 1'b0;
            end
            if (b == nbits - 1 && j == C - 1)
               check($sformatf("ready_last_cycle dut%0d", idx), 32'(get_ready(idx)), 32'(0));
            @(posedge clk);
            #1;
         end
         check($sformatf("dut%0d data 0x%02h bit%0d", idx, d, b), 32'(samp), 32'({C{expb[b]}}));
      end
      check($sformatf("ready_after dut%0d", idx), 32'(get_ready(idx)), 32'(1));
      check($sformatf("tmr_set_count dut%0d", idx), 32'(sets), 32'(nbits));
      check($sformatf("tmr_set_idle dut%0d", idx), 32'(get_set(idx)), 32'(0));
      $display("frame dut%0d data=0x%02h bits=%0d accepted at %0t", idx, d, nbits, t_acc);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      time t1, t2;
      data_v[0]  = 8'h00;
      data_v[1]  = 8'h00;
      valid_v[0] = 1'b0;
      valid_v[1] = 1'b0;
      force_done = 1'b0;

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("reset txd0",      32'(txd0),          32'(1));
      check("reset txd1",      32'(txd1),          32'(1));
      check("reset ready0",    32'(bus0.tx_ready), 32'(1));
      check("reset busy0",     32'(bus0.tx_busy),  32'(0));
      check("reset set0",      32'(set0),          32'(0));
      check("tmr_value0",      32'(val0),          32'(C - 1));
      $display("reset released at %0t", $time);

      // Basic frames
      run_frame(0, 8'hA5, NB, EXP_A5, 1'b0, 8'h00, 1'b0, t1);
      run_frame(0, 8'h07, NB, EXP_07, 1'b0, 8'h00, 1'b0, t1);

      // Back-to-back with tx_valid held: next accept one clock after stop
      run_frame(0, 8'h00, NB, EXP_00, 1'b1, 8'hFF, 1'b0, t1);
      run_frame(0, 8'hFF, NB, EXP_FF, 1'b0, 8'h00, 1'b0, t2);
      check("b2b_gap_clks", 32'((t2 - t1) / 10), 32'(NB * C + 1));
      $display("back-to-back gap %0d clocks", 32'((t2 - t1) / 10));

      // tmr_done while idle is ignored
      @(negedge clk);
      force_done = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_done txd",   32'(txd0),          32'(1));
      check("idle_done ready", 32'(bus0.tx_ready), 32'(1));
      check("idle_done set",   32'(set0),          32'(0));
      @(negedge clk);
      force_done = 1'b0;
      $display("idle tmr_done pulse done");

      // tx_valid toggled with other data mid-frame
      run_frame(0, 8'hA5, NB, EXP_A5, 1'b0, 8'h00, 1'b1, t1);

      // Two stop bits
      run_frame(1, 8'h3C, NB + 1, EXP_3C2, 1'b0, 8'h00, 1'b0, t1);

      // Reset in the middle of a frame
      @(negedge clk);
      data_v[0]  = 8'h00;
      valid_v[0] = 1'b1;
      @(posedge clk);
      #1;
      valid_v[0] = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("midframe txd before rst", 32'(txd0), 32'(0));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst txd",   32'(txd0),          32'(1));
      check("rst ready", 32'(bus0.tx_ready), 32'(1));
      check("rst set",   32'(set0),          32'(0));
      @(posedge clk);
      #1;
      check("rst set next", 32'(set0),      32'(0));
      check("rst txd next", 32'(txd0),      32'(1));
      $display("mid-frame reset done");

      // Normal operation after the abandoned frame
      run_frame(0, 8'h07, NB, EXP_07, 1'b0, 8'h00, 1'b0, t1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
